// File: rtl/max_uint16_serial.sv
// ---------------------------------------------------------------------------
// max_uint16_serial
//   Bit-serial unsigned maximum of two WIDTH-bit operands. The operands are
//   latched on start. Each RUN cycle compares one bit pair, MSB first, and
//   the first differing pair decides which operand is larger. When the compare
//   finishes, Y/a_gt_b are updated and done pulses for one cycle.
//
//   Optional build macro: MAX_SERIAL_EARLY_EXIT_EN
//     defined   - RUN ends in the cycle that finds the first differing bit.
//     undefined - RUN always lasts WIDTH cycles.
//     The results are the same in both builds. Only the latency changes.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   begin a compare (sampled only in IDLE or DONE)
//   A, B    in   WIDTH-bit unsigned operands, sampled with start
//   busy    out  high while in RUN
//   done    out  one-cycle pulse when Y/a_gt_b become valid
//   Y       out  max(A,B) of the last completed compare (equal -> B)
//   a_gt_b  out  A > B (strict) of the last completed compare
// ---------------------------------------------------------------------------
module max_uint16_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             a_gt_b
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic [IW-1:0]    idx_q;
  logic             dec_q;
  logic             gt_q;
  logic             agtb_q;

  logic             bit_a;
  logic             bit_b;
  logic             hit;
  logic             gt_d;
  logic             last;

  // hit: the current bit pair is the first one that differs.
  // gt_d: the gt flag after this bit pair is taken into account. It is used
  // directly so that the result loaded on leaving RUN includes the final bit.
  always_comb begin
    bit_a = a_q[idx_q];
    bit_b = b_q[idx_q];
    hit   = !dec_q && (bit_a != bit_b);
    gt_d  = hit ? bit_a : gt_q;
`ifdef MAX_SERIAL_EARLY_EXIT_EN
    last  = (idx_q == '0) || hit;
`else
    last  = (idx_q == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      agtb_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            idx_q   <= IW'(WIDTH - 1);
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (hit) begin
            dec_q <= 1'b1;
            gt_q  <= bit_a;
          end
          idx_q <= idx_q - IW'(1);
          if (last) begin
            y_q     <= gt_d ? a_q : b_q;
            agtb_q  <= gt_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign Y      = y_q;
  assign a_gt_b = agtb_q;

endmodule

// File: tb/tb_max_uint16_serial.sv
// Testbench for max_uint16_serial. A transaction-level model predicts the
// busy/done/Y/a_gt_b outputs cycle by cycle. A monitor compares the DUT
// against that model on every falling edge. Directed cases pin the model
// against hand-computed values.
module tb_max_uint16_serial;

  localparam int W   = 16;
  localparam int LIM = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic         a_gt_b;

  int checks;
  int errors;
  bit stim_done;

  max_uint16_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Y      (Y),
    .a_gt_b (a_gt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of busy cycles a compare takes.
  function automatic int run_len(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
`ifdef MAX_SERIAL_EARLY_EXIT_EN
    if (x != '0) begin
      for (int i = W - 1; i >= 0; i--)
        if (x[i]) return W - i;
    end
`endif
    if (x == '0) return W;
    return W;
  endfunction

  // Cycle-level reference model.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_y;
  logic         m_gt;
  logic [W-1:0] r_y;
  logic         r_gt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_y    <= '0;
      m_gt   <= 1'b0;
      r_y    <= '0;
      r_gt   <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_y    <= r_y;
        m_gt   <= r_gt;
        m_left <= 0;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (start) begin
        r_y    <= (A > B) ? A : B;
        r_gt   <= (A > B);
        m_left <= run_len(A, B);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives start now, then follows the compare until done.
  // Latency counts the start cycle as cycle 0.
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ey, input logic egt,
                     input int elat, input string nm);
    int lat;
    int busyc;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    lat = 1;
    busyc = 0;
    while (!done && lat < LIM) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, elat);
    check({nm, "_busycycles"}, busyc, elat - 1);
    check({nm, "_Y"}, Y, ey);
    check({nm, "_a_gt_b"}, a_gt_b, egt);
  endtask

`ifdef MAX_SERIAL_EARLY_EXIT_EN
  localparam int LAT_MSB = 2;
  localparam int LAT_73  = 15;
`else
  localparam int LAT_MSB = 17;
  localparam int LAT_73  = 17;
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    stim_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    A         = '0;
    B         = '0;
    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (!stim_done) begin
            check("mon_busy", busy, (m_left != 0));
            check("mon_done", done, m_done);
            check("mon_Y", Y, m_y);
            check("mon_a_gt_b", a_gt_b, m_gt);
          end
        end
      end
      begin
        int ndone;
        logic [W-1:0] ylast;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_Y", Y, 0);
        check("rst_a_gt_b", a_gt_b, 0);
        rst_n = 1'b1;

        @(negedge clk);
        txn(16'h1234, 16'h1235, 16'h1235, 1'b0, 17, "t1234");
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);

        @(negedge clk);
        txn(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 17, "equal");

        @(negedge clk);
        txn(16'h8000, 16'h7FFF, 16'h8000, 1'b1, LAT_MSB, "msb");
        // Still in the DONE cycle: issue the next compare back-to-back.
        check("b2b_prior_Y", Y, 16'h8000);
        check("b2b_prior_done", done, 1);
        txn(16'h0007, 16'h0003, 16'h0007, 1'b1, LAT_73, "b2b");

        // A start issued during RUN is ignored.
        @(negedge clk);
        A = 16'd5;
        B = 16'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        A = 16'hFFFF;
        B = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        ylast = '0;
        for (int i = 0; i < LIM; i++) begin
          if (done) begin ndone++; ylast = Y; end
          @(posedge clk); #1;
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_Y", ylast, 16'd9);
        check("ignore_a_gt_b", a_gt_b, 0);

        // Reset in RUN cycle 8.
        @(negedge clk);
        A = 16'h00F0;
        B = 16'h0F00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_Y", Y, 0);
        check("midrst_a_gt_b", a_gt_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < LIM; i++) begin
          @(posedge clk); #1;
          if (done || busy) ndone++;
        end
        check("postrst_quiet", ndone, 0);

        // Random traffic, checked by the monitor.
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          start = ($urandom_range(0, 2) == 0);
          A = W'($urandom);
          case ($urandom_range(0, 3))
            0:       B = A;
            1:       B = A ^ (W'(1) << $urandom_range(0, W - 1));
            default: B = W'($urandom);
          endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        stim_done = 1'b1;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
